// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver and scan-code decoder.
// kbclk/kbdata are synchronised into clk and kbclk is glitch-filtered.
// 11-bit frames are assembled with stop/parity checks and a timeout.
// E0/E1/F0 prefixes become ext/brk flags on the next code.
// Decoded events are queued in a FIFO with a valid/ready interface.
// Optional build macro: PS2_PARITY_CHECK_EN
//   defined   -> a frame with bad odd parity is dropped with frame_err.
//   undefined -> the parity bit is captured but ignored.
module ps2_kbd_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          kbclk,
   input  logic                          kbdata,
   output logic [9:0]                    evt_data,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          frame_err,
   output logic                          ovf
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK_EN = 1'b1;
`else
   localparam bit PAR_CHK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // True when data bits plus parity bit hold an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] d, input logic p);
      odd_parity = ^{d, p};
   endfunction

   // Stop bit must be 1; parity only counts when the check is enabled.
   function automatic logic frame_ok(input logic stop, input logic [7:0] d, input logic p);
      frame_ok = stop && (!PAR_CHK_EN || odd_parity(d, p));
   endfunction

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] dat_sync_r;
   logic                   filt_r;
   logic [FW-1:0]          filt_cnt_r;
   logic                   strobe_r;
   logic                   smp_r;
   state_t                 state_r;
   logic [2:0]             bit_cnt_r;
   logic [7:0]             shift_r;
   logic                   par_r;
   logic [TW-1:0]          tmo_r;
   logic                   byte_stb_r;
   logic [7:0]             byte_r;
   logic                   ferr_r;
   logic                   ext_r;
   logic                   brk_r;
   logic                   push_s;
   logic [9:0]             push_data_s;
   logic [9:0]             mem_r [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [CW-1:0]          cnt_r;
   logic                   ovf_r;
   logic                   full_s;
   logic                   pop_s;
   logic                   wr_en_s;
   logic                   clk_s_s;
   logic                   dat_s_s;

   assign clk_s_s = clk_sync_r[SYNC_STAGES-1];
   assign dat_s_s = dat_sync_r[SYNC_STAGES-1];

   // Synchronise the raw PS/2 lines into the clk domain (idle high).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_r <= '1;
         dat_sync_r <= '1;
      end else begin
         clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], kbclk};
         dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], kbdata};
      end
   end

   // Glitch filter on kbclk; a filtered falling edge gives a one-cycle strobe.
   // The data sample is registered alongside so both line up on the strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_r     <= 1'b1;
         filt_cnt_r <= '0;
         strobe_r   <= 1'b0;
         smp_r      <= 1'b1;
      end else begin
         strobe_r <= 1'b0;
         smp_r    <= dat_s_s;
         if (clk_s_s != filt_r) begin
            if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
               filt_r     <= clk_s_s;
               filt_cnt_r <= '0;
               strobe_r   <= filt_r;
            end else begin
               filt_cnt_r <= filt_cnt_r + 1'b1;
            end
         end else begin
            filt_cnt_r <= '0;
         end
      end
   end

   // Frame FSM: advances on strobes, aborts an in-progress frame on timeout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         par_r      <= 1'b0;
         tmo_r      <= '0;
         byte_stb_r <= 1'b0;
         byte_r     <= 8'h00;
         ferr_r     <= 1'b0;
      end else begin
         byte_stb_r <= 1'b0;
         ferr_r     <= 1'b0;
         if (strobe_r) begin
            tmo_r <= '0;
            case (state_r)
               ST_IDLE: begin
                  if (!smp_r) begin
                     state_r   <= ST_DATA;
                     bit_cnt_r <= 3'd0;
                     shift_r   <= 8'h00;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_DATA: begin
                  shift_r   <= {smp_r, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= ST_PARITY;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
               ST_PARITY: begin
                  par_r   <= smp_r;
                  state_r <= ST_STOP;
               end
               ST_STOP: begin
                  state_r <= ST_IDLE;
                  if (frame_ok(smp_r, shift_r, par_r)) begin
                     byte_stb_r <= 1'b1;
                     byte_r     <= shift_r;
                  end else begin
                     ferr_r <= 1'b1;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end else if (state_r != ST_IDLE) begin
            if (tmo_r == TW'(TIMEOUT_CYCLES - 1)) begin
               state_r <= ST_IDLE;
               tmo_r   <= '0;
               ferr_r  <= 1'b1;
            end else begin
               tmo_r <= tmo_r + 1'b1;
            end
         end else begin
            tmo_r <= '0;
         end
      end
   end

   // Decode a received byte into a FIFO push (prefix bytes push nothing).
   always_comb begin
      push_s      = 1'b0;
      push_data_s = 10'h000;
      if (byte_stb_r) begin
         case (byte_r)
            8'hE0, 8'hE1, 8'hF0: begin
               push_s = 1'b0;
            end
            default: begin
               push_s      = 1'b1;
               push_data_s = {ext_r, brk_r, byte_r};
            end
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

   // Pending prefix flags survive frame errors and clear only on a pushed event.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ext_r <= 1'b0;
         brk_r <= 1'b0;
      end else if (byte_stb_r) begin
         case (byte_r)
            8'hE0, 8'hE1: ext_r <= 1'b1;
            8'hF0:        brk_r <= 1'b1;
            default: begin
               ext_r <= 1'b0;
               brk_r <= 1'b0;
            end
         endcase
      end else begin
         ext_r <= ext_r;
         brk_r <= brk_r;
      end
   end

   assign full_s  = (cnt_r == CW'(FIFO_DEPTH));
   assign pop_s   = (cnt_r != '0) && evt_ready;
   assign wr_en_s = push_s && (!full_s || pop_s);

   // Event FIFO: circular buffer, drop-and-flag when full without a pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 10'h000;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         ovf_r    <= 1'b0;
      end else begin
         ovf_r <= push_s && full_s && !pop_s;
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({wr_en_s, pop_s})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign evt_data  = mem_r[rd_ptr_r];
   assign evt_valid = (cnt_r != '0);
   assign evt_count = cnt_r;
   assign frame_err = ferr_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx.
module tb_ps2_kbd_rx;

   localparam int TMO = 2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       kbclk = 1'b1;
   logic       kbdata = 1'b1;
   logic       evt_ready = 1'b0;
   logic [9:0] evt_data;
   logic       evt_valid;
   logic [3:0] evt_count;
   logic       frame_err;
   logic       ovf;

   int checks = 0;
   int failures = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   int vld_cycles = 0;
   logic [9:0] ev_q[$];

   ps2_kbd_rx #(
      .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .kbclk(kbclk), .kbdata(kbdata),
      .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_count(evt_count), .frame_err(frame_err), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Observe outputs on the falling edge: pulses, valid cycles, popped events.
   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (ovf) ovf_cnt++;
      if (evt_valid) vld_cycles++;
      if (evt_valid && evt_ready) ev_q.push_back(evt_data);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] get_ev(input int idx);
      if (idx < ev_q.size()) get_ev = ev_q[idx];
      else get_ev = 10'h3FF;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      kbdata = b;
      tick(10);
      kbclk = 1'b0;
      tick(20);
      kbclk = 1'b1;
      tick(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip_par);
      logic p;
      p = ~(^b) ^ flip_par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(1'b1);
      kbdata = 1'b1;
      tick(20);
   endtask

   initial begin
      int eb;
      int e0;
      // Reset state
      tick(5);
      check_val("rst_valid", {31'd0, evt_valid}, 32'd0);
      check_val("rst_count", {28'd0, evt_count}, 32'd0);
      check_val("rst_data", {22'd0, evt_data}, 32'd0);
      check_val("rst_ferr", {31'd0, frame_err}, 32'd0);
      check_val("rst_ovf", {31'd0, ovf}, 32'd0);
      rst_n = 1'b1;
      tick(5);

      // 1: single clean make code
      evt_ready = 1'b1;
      eb = ev_q.size(); e0 = err_cnt; vld_cycles = 0;
      send_frame(8'h1C, 1'b0);
      tick(10);
      check_val("t1_nevt", ev_q.size() - eb, 32'd1);
      check_val("t1_data", {22'd0, get_ev(eb)}, 32'h01C);
      check_val("t1_vld_cycles", vld_cycles, 32'd1);
      check_val("t1_ferr", err_cnt - e0, 32'd0);

      // 2: break and extended-break prefixes
      eb = ev_q.size();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      tick(10);
      check_val("t2_nevt", ev_q.size() - eb, 32'd2);
      check_val("t2_ev0", {22'd0, get_ev(eb)}, 32'h11C);
      check_val("t2_ev1", {22'd0, get_ev(eb + 1)}, 32'h375);

      // 3: bad parity bit
      eb = ev_q.size(); e0 = err_cnt;
      send_frame(8'h1C, 1'b1);
      tick(10);
`ifdef PS2_PARITY_CHECK_EN
      check_val("t3_ferr", err_cnt - e0, 32'd1);
      check_val("t3_nevt", ev_q.size() - eb, 32'd0);
      check_val("t3_count", {28'd0, evt_count}, 32'd0);
`else
      check_val("t3_ferr", err_cnt - e0, 32'd0);
      check_val("t3_nevt", ev_q.size() - eb, 32'd1);
      check_val("t3_data", {22'd0, get_ev(eb)}, 32'h01C);
`endif

      // 4: partial frame then timeout, then recovery
      e0 = err_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      tick(TMO + 100);
      check_val("t4_ferr", err_cnt - e0, 32'd1);
      eb = ev_q.size();
      send_frame(8'h29, 1'b0);
      tick(10);
      check_val("t4_nevt", ev_q.size() - eb, 32'd1);
      check_val("t4_data", {22'd0, get_ev(eb)}, 32'h029);
      check_val("t4_ferr_after", err_cnt - e0, 32'd1);

      // 5: overflow with consumer stalled, then drain in order
      evt_ready = 1'b0;
      e0 = ovf_cnt;
      for (int i = 0; i < 9; i++) send_frame(8'h15 + 8'(i), 1'b0);
      tick(10);
      check_val("t5_count_full", {28'd0, evt_count}, 32'd8);
      check_val("t5_ovf", ovf_cnt - e0, 32'd1);
      check_val("t5_head", {22'd0, evt_data}, 32'h015);
      eb = ev_q.size();
      evt_ready = 1'b1;
      tick(20);
      check_val("t5_ndrain", ev_q.size() - eb, 32'd8);
      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("t5_drain%0d", i), {22'd0, get_ev(eb + i)}, 32'h015 + i);
      end
      check_val("t5_count_empty", {28'd0, evt_count}, 32'd0);

      // 6: short kbclk glitches while idle, then reset mid-frame
      e0 = err_cnt; eb = ev_q.size();
      kbdata = 1'b0;
      for (int i = 0; i < 3; i++) begin
         kbclk = 1'b0;
         tick(1);
         kbclk = 1'b1;
         tick(10);
      end
      kbdata = 1'b1;
      tick(TMO + 100);
      check_val("t6_glitch_ferr", err_cnt - e0, 32'd0);
      check_val("t6_glitch_nevt", ev_q.size() - eb, 32'd0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(2);
      check_val("t6_rst_valid", {31'd0, evt_valid}, 32'd0);
      check_val("t6_rst_count", {28'd0, evt_count}, 32'd0);
      send_frame(8'h1C, 1'b0);
      tick(10);
      check_val("t6_nevt", ev_q.size() - eb, 32'd1);
      check_val("t6_data", {22'd0, get_ev(eb)}, 32'h01C);
      check_val("t6_ferr", err_cnt - e0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Fully synchronous PS/2 keyboard receiver and scan-code decoder. Successor to the single-byte display receiver.
- Samples kbclk/kbdata in the system clock domain, filters the PS/2 clock, frames 11-bit packets with parity/stop check and timeout.
- Folds E0/E1/F0 prefixes into flags on the following code.
- Buffers decoded key events in a parametrised FIFO with a valid/ready interface for downstream display or CPU logic.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on kbclk and kbdata (min 2).
- FILTER_LEN, 4, consecutive identical kbclk samples required to change the filtered clock level (min 1).
- TIMEOUT_CYCLES, 50000, clk cycles without a sample strobe before an in-progress frame aborts.
- FIFO_DEPTH, 8, event FIFO entries; power of two, min 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, synchronous, active-low.
- kbclk, input, 1, raw PS/2 clock, asynchronous.
- kbdata, input, 1, raw PS/2 data, asynchronous.
- evt_data, output, 10, head event {ext, brk, code[7:0]}.
- evt_valid, output, 1, FIFO not empty.
- evt_ready, input, 1, consumer pops the head when evt_valid && evt_ready.
- evt_count, output, $clog2(FIFO_DEPTH)+1, current fill level.
- frame_err, output, 1, one-cycle pulse on any framing, stop, parity or timeout error.
- ovf, output, 1, one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset is synchronous and active-low, sampled on the posedge of clk. It applies at any time, including mid-frame:
  - FSM goes to IDLE; bit counter, shift register, timeout counter and prefix flags clear.
  - Synchroniser outputs and filtered clock go to 1; FIFO empties.
  - Outputs: evt_valid=0, evt_count=0, evt_data=0, frame_err=0, ovf=0.
- Filter: filtered clock takes the synchronised kbclk level only after FILTER_LEN consecutive equal samples. A 1->0 transition of the filtered clock produces a one-cycle strobe. kbdata (synchronised) is sampled on the strobe cycle.
- Frame FSM, transitions on strobe only:
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE, no error.
  - DATA: shift bit in LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: data=1 and odd parity over 8 data bits + parity bit -> byte strobe. Otherwise frame_err pulse. Go to IDLE in both cases.
- Timeout: counter clears on every strobe and counts while the FSM is not IDLE. Reaching TIMEOUT_CYCLES -> IDLE plus frame_err pulse; the partial byte is discarded.
- Decoder, on byte strobe:
  - E0 or E1: set ext_pend, no event.
  - F0: set brk_pend, no event.
  - Any other byte: push {ext_pend, brk_pend, byte} and clear both pending flags.
  - Pending flags persist across frame errors; they clear only on a pushed event or reset.
- Latency: stop-bit strobe in cycle N -> event written at the end of N+1 -> evt_valid=1 in N+2 when the FIFO was empty.
- FIFO: circular buffer; pointers wrap modulo FIFO_DEPTH. evt_data shows the head entry.
  - Push while full and no pop: event dropped, ovf pulses, contents unchanged.
  - Simultaneous push and pop: both happen, count unchanged. This holds when full (no ovf) and when empty with count 0 (the pop is ignored because evt_valid=0, so count becomes 1).
- No combinational path from evt_ready to evt_valid or evt_data.

Optional Feature:
- PS2_PARITY_CHECK_EN.
- Defined: odd-parity failure in STOP raises frame_err and the byte is dropped, as above.
- Undefined: the parity bit is captured but ignored. Only a stop bit of 0 or a timeout raises frame_err; all else identical.

Test Plan:
- 1. Frame 0x1C, odd parity bit 0, stop 1; evt_ready=1 -> exactly one event, evt_data=0x01C, evt_valid for 1 cycle, frame_err never pulses.
- 2. Bytes F0,1C, then E0,F0,75 -> events 0x11C then 0x375. The F0 and E0 prefixes produce no events.
- 3. Frame 0x1C with parity bit 1 -> with PS2_PARITY_CHECK_EN: frame_err pulse, evt_count stays 0. Without it: event 0x01C.
- 4. Start bit plus 3 data bits, then kbclk held high for TIMEOUT_CYCLES -> single frame_err pulse, FSM in IDLE. A following clean 0x29 frame yields event 0x029.
- 5. evt_ready=0; send FIFO_DEPTH+1 codes 0x15..0x1D (depth 8) -> evt_count=8, one ovf pulse on the 9th. Draining returns 0x015..0x01C in order.
- 6. 1-cycle kbclk low glitches (FILTER_LEN=4) while idle -> no strobe, no error. rst_n=0 for 1 cycle mid-frame, then a clean 0x1C frame -> exactly event 0x01C.
